// File: rtl/rsqrt_pkg.sv
// Shared definitions for the sequential integer square-root unit.
package rsqrt_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE    = 2'd0,
        S_ITER    = 2'd1,
        S_DONE    = 2'd2,
        S_ILLEGAL = 2'd3
    } state_t;

    // Number of iteration cycles for a legal configuration, 0 if illegal.
    function automatic int unsigned calc_iters(input int unsigned width,
                                               input int unsigned ipc);
        if (width < 4 || (width % 2) != 0) return 0;
        if (!(ipc == 1 || ipc == 2 || ipc == 4)) return 0;
        if ((width % (2 * ipc)) != 0) return 0;
        return width / (2 * ipc);
    endfunction

endpackage

// File: rtl/rsqrt_step.sv
// One restoring square-root recurrence step: consumes the top two radicand bits
// and resolves one root bit.
module rsqrt_step #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH/2-1:0] i_q,
    input  logic [WIDTH/2+1:0] i_r,
    input  logic [WIDTH-1:0]   i_x,
    output logic [WIDTH/2-1:0] o_q,
    output logic [WIDTH/2+1:0] o_r,
    output logic [WIDTH-1:0]   o_x
);

    localparam int unsigned HALF = WIDTH / 2;

    logic [HALF+1:0] w_r_sh;
    logic [HALF+2:0] w_diff;
    logic            w_borrow;
    logic            w_unused;

    // Partial remainder never exceeds 2*q, so its top two bits are always zero here.
    assign w_r_sh   = {i_r[HALF-1:0], i_x[WIDTH-1 -: 2]};
    // One extra bit so the borrow of the trial subtraction is explicit.
    assign w_diff   = {1'b0, w_r_sh} - {1'b0, i_q, 2'b01};
    assign w_borrow = w_diff[HALF+2];

    assign o_r = w_borrow ? w_r_sh : w_diff[HALF+1:0];
    // q has fewer than HALF significant bits before the last step, so its MSB drops safely.
    assign o_q = {i_q[HALF-2:0], ~w_borrow};
    assign o_x = {i_x[WIDTH-3:0], 2'b00};

    assign w_unused = ^{i_r[HALF+1:HALF], i_q[HALF-1]};

endmodule

// File: rtl/rsqrt_seq_v2.sv
// Sequential integer square root with start/done handshake; ITER_PER_CYCLE
// recurrence steps are chained per clock.
module rsqrt_seq_v2
    import rsqrt_pkg::*;
#(
    parameter int unsigned WIDTH          = 16,
    parameter int unsigned ITER_PER_CYCLE = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     radicand,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH/2-1:0]   root,
    output logic [WIDTH/2:0]     remainder,
    output logic [STATE_W-1:0]   state
);

    localparam int unsigned HALF  = WIDTH / 2;
    localparam int unsigned N     = calc_iters(WIDTH, ITER_PER_CYCLE);
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

    if (N == 0) begin : g_bad_params
        $error("rsqrt_seq_v2: illegal WIDTH / ITER_PER_CYCLE combination");
    end

    state_t           r_ps;
    logic [HALF-1:0]  r_q;
    logic [HALF+1:0]  r_r;
    logic [WIDTH-1:0] r_x;
    logic [CNT_W-1:0] r_cnt;

    logic [HALF-1:0]  w_q [ITER_PER_CYCLE+1];
    logic [HALF+1:0]  w_r [ITER_PER_CYCLE+1];
    logic [WIDTH-1:0] w_x [ITER_PER_CYCLE+1];
    logic             w_unused_r;

    assign w_q[0] = r_q;
    assign w_r[0] = r_r;
    assign w_x[0] = r_x;

    for (genvar g = 0; g < ITER_PER_CYCLE; g++) begin : g_step
        rsqrt_step #(
            .WIDTH(WIDTH)
        ) u_step (
            .i_q(w_q[g]),
            .i_r(w_r[g]),
            .i_x(w_x[g]),
            .o_q(w_q[g+1]),
            .o_r(w_r[g+1]),
            .o_x(w_x[g+1])
        );
    end

    assign state = r_ps;
    // Final remainder is at most 2*root, so the top bit of r is always zero by then.
    assign w_unused_r = r_r[HALF+1];

    // Control FSM, datapath registers and registered handshake outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ps      <= S_IDLE;
            r_q       <= '0;
            r_r       <= '0;
            r_x       <= '0;
            r_cnt     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            root      <= '0;
            remainder <= '0;
        end else begin
            case (r_ps)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_x   <= radicand;
                        r_q   <= '0;
                        r_r   <= '0;
                        r_cnt <= CNT_W'(N - 1);
                        busy  <= 1'b1;
                        r_ps  <= S_ITER;
                    end
                end
                S_ITER: begin
                    r_q <= w_q[ITER_PER_CYCLE];
                    r_r <= w_r[ITER_PER_CYCLE];
                    r_x <= w_x[ITER_PER_CYCLE];
                    if (r_cnt == '0) begin
                        r_ps <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    root      <= r_q;
                    remainder <= r_r[HALF:0];
                    r_ps      <= S_IDLE;
                end
                default: begin
                    busy <= 1'b0;
                    done <= 1'b0;
                    r_ps <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rsqrt_seq_v2.sv
// Scoreboard bench for rsqrt_seq_v2: stimulus pushes expected results, a
// negedge monitor pops and compares on every done pulse.
module tb_rsqrt_seq_v2;

    typedef struct {
        logic [7:0] root;
        logic [8:0] rem;
        int         acc;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] radicand;
    logic        busy, done;
    logic [7:0]  root;
    logic [8:0]  remainder;
    logic [1:0]  state;

    logic        s24;
    logic [15:0] rad24;
    logic        busy2, done2, busy4, done4;
    logic [7:0]  root2, root4;
    logic [8:0]  rem2, rem4;
    logic [1:0]  state2, state4;

    exp_t sb[$];
    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;
    int   cyc      = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    rsqrt_seq_v2 #(.WIDTH(16), .ITER_PER_CYCLE(1)) dut (
        .clock(clock), .reset(reset), .start(start), .radicand(radicand),
        .busy(busy), .done(done), .root(root), .remainder(remainder), .state(state)
    );
    rsqrt_seq_v2 #(.WIDTH(16), .ITER_PER_CYCLE(2)) dut2 (
        .clock(clock), .reset(reset), .start(s24), .radicand(rad24),
        .busy(busy2), .done(done2), .root(root2), .remainder(rem2), .state(state2)
    );
    rsqrt_seq_v2 #(.WIDTH(16), .ITER_PER_CYCLE(4)) dut4 (
        .clock(clock), .reset(reset), .start(s24), .radicand(rad24),
        .busy(busy4), .done(done4), .root(root4), .remainder(rem4), .state(state4)
    );

    function automatic int ref_root(input int v);
        int r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clock) begin
        if (done === 1'b1) begin
            exp_t e;
            done_cnt++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done with empty scoreboard (t=%0t)", $time);
            end else begin
                e = sb.pop_front();
                check("root", {24'd0, root}, {24'd0, e.root});
                check("remainder", {23'd0, remainder}, {23'd0, e.rem});
                check("latency", cyc - e.acc, 9);
            end
        end
    end

    task automatic issue(input logic [15:0] v);
        exp_t e;
        int   rr;
        @(negedge clock);
        start    = 1'b1;
        radicand = v;
        @(posedge clock);
        #1;
        start    = 1'b0;
        radicand = ~v;
        rr       = ref_root(int'(v));
        e.root   = rr[7:0];
        rr       = int'(v) - rr * rr;
        e.rem    = rr[8:0];
        e.acc    = cyc;
        sb.push_back(e);
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_cnt < target && n < 40) begin
            @(negedge clock);
            n++;
        end
        @(negedge clock);
        if (done_cnt < target) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got %0d dones expected %0d", done_cnt, target);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int lat2, lat4;
        reset    = 1'b1;
        start    = 1'b0;
        radicand = '0;
        s24      = 1'b0;
        rad24    = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_state", {30'd0, state}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_root", {24'd0, root}, 0);
        check("rst_rem", {23'd0, remainder}, 0);

        // Reset and start together: reset wins.
        @(negedge clock);
        start    = 1'b1;
        radicand = 16'd5;
        @(posedge clock);
        #1;
        check("rst_start_state", {30'd0, state}, 0);
        check("rst_start_busy", {31'd0, busy}, 0);
        @(negedge clock);
        reset = 1'b0;
        start = 1'b0;

        issue(16'd144);   wait_done(1);
        issue(16'd145);   wait_done(2);
        issue(16'd0);     wait_done(3);
        issue(16'd65535); wait_done(4);

        // Extra start pulses during a run are ignored.
        issue(16'd1000);
        repeat (2) @(negedge clock);
        start = 1'b1; radicand = 16'd9;
        @(negedge clock);
        start = 1'b0;
        repeat (2) @(negedge clock);
        start = 1'b1; radicand = 16'd4;
        @(negedge clock);
        start = 1'b0;
        wait_done(5);
        repeat (12) @(negedge clock);
        check("no_extra_done", done_cnt, 5);
        check("sb_empty_run", sb.size(), 0);

        // Reset in the 4th iteration cycle discards the computation.
        @(negedge clock);
        start    = 1'b1;
        radicand = 16'd40000;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("iter_state", {30'd0, state}, 1);
        check("iter_busy", {31'd0, busy}, 1);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("abort_state", {30'd0, state}, 0);
        check("abort_busy", {31'd0, busy}, 0);
        check("abort_root", {24'd0, root}, 0);
        check("abort_rem", {23'd0, remainder}, 0);
        @(negedge clock);
        reset = 1'b0;
        repeat (14) @(negedge clock);
        check("abort_no_done", done_cnt, 5);
        issue(16'd40000); wait_done(6);

        // Random operands against the reference model.
        for (int i = 0; i < 60; i++) begin
            issue(16'($urandom_range(0, 65535)));
            wait_done(7 + i);
        end

        // Wider retirement: latency N+1 with N = 4 and 2.
        @(negedge clock);
        s24   = 1'b1;
        rad24 = 16'd50000;
        @(posedge clock);
        #1;
        s24   = 1'b0;
        rad24 = 16'd0;
        lat2  = 0;
        lat4  = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clock);
            #1;
            if (done2 === 1'b1 && lat2 == 0) begin
                lat2 = k;
                check("ipc2_root", {24'd0, root2}, 223);
                check("ipc2_rem", {23'd0, rem2}, 271);
            end
            if (done4 === 1'b1 && lat4 == 0) begin
                lat4 = k;
                check("ipc4_root", {24'd0, root4}, 223);
                check("ipc4_rem", {23'd0, rem4}, 271);
            end
        end
        check("ipc2_latency", lat2, 5);
        check("ipc4_latency", lat4, 3);

        repeat (3) @(negedge clock);
        check("sb_empty_end", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
